// File: rtl/onfi_burst_io.sv
// -----------------------------------------------------------------------------
// onfi_burst_io
//
// NAND data-path IO engine. Moves one multi-word burst per request between the
// controller's valid/ready streams and the ONFI DQ pads, generating the WE#/RE#
// strobe with T_SETUP low cycles and T_HOLD high cycles per word. Reads sample
// the DQ pads on low cycle T_CAPTURE into a one-deep output register; writes
// fetch one stream word per strobe pulse and drive it on the DQ pads.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, dir        burst request (0 = read NAND, 1 = write NAND), IDLE only
//   burst_len         words in the burst, latched on start
//   s_data/valid/ready  write stream (controller -> NAND)
//   m_data/valid/ready  read stream  (NAND -> controller)
//   nand_dq_in/out/oe DQ pad input, output and output enable
//   strobe_n          WE#/RE# strobe, active low
//   busy              high whenever the engine is not IDLE
//   initialized       sticky high once the post-reset settle count expires
//   done              one-cycle pulse at the end of a burst
//   words_left        remaining words in the current burst
//   checksum          (optional) XOR of every word moved in the last burst
//
// Optional feature: define ONFI_IO_CHECKSUM_EN to add the checksum port.
// -----------------------------------------------------------------------------
module onfi_burst_io #(
  parameter int DATA_W      = 16,
  parameter int T_SETUP     = 4,
  parameter int T_HOLD      = 2,
  parameter int T_CAPTURE   = 3,
  parameter int INIT_CYCLES = 15,
  parameter int LEN_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] nand_dq_in,
  output logic [DATA_W-1:0] nand_dq_out,
  output logic              nand_dq_oe,
  output logic              strobe_n,
  output logic              busy,
  output logic              initialized,
  output logic              done,
  output logic [LEN_W-1:0]  words_left
`ifdef ONFI_IO_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int PH_MAX = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);

  localparam logic [PH_W-1:0]   LOW_LAST  = PH_W'(T_SETUP - 1);
  localparam logic [PH_W-1:0]   HIGH_LAST = PH_W'(T_HOLD - 1);
  localparam logic [PH_W-1:0]   CAP_AT    = PH_W'(T_CAPTURE - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_FETCH,
    S_LOW,
    S_HIGH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [PH_W-1:0]   ph_cnt;
  logic [INIT_W-1:0] init_cnt;
  logic              dir_q;
  logic              held;       // word_left already decremented, stalled in HIGH

  logic              start_ok;
  logic              fetch_hs;
  logic              capture;
  logic              high_end;
  logic              word_dec;
  logic [LEN_W-1:0]  words_rem;
  logic              stall;

  assign start_ok  = (state == S_IDLE) && start;
  assign fetch_hs  = (state == S_FETCH) && s_valid;
  assign capture   = (state == S_LOW) && !dir_q && (ph_cnt == CAP_AT);
  // ph_cnt parks on HIGH_LAST while stalled, so high_end stays true and the
  // held flag keeps the word from being counted twice.
  assign high_end  = (state == S_HIGH) && (ph_cnt == HIGH_LAST);
  assign word_dec  = high_end && !held;
  assign words_rem = word_dec ? (words_left - LEN_W'(1)) : words_left;
  // A new read LOW may only start once the output register is free or is
  // being emptied on this very cycle.
  assign stall     = high_end && !dir_q && (words_rem != '0) && m_valid && !m_ready;

  assign busy     = (state != S_IDLE);
  assign s_ready  = (state == S_FETCH);
  assign strobe_n = (state != S_LOW);
  assign done     = (state == S_DONE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:  if (init_cnt == INIT_LAST) state_nx = S_IDLE;
      S_IDLE: begin
        if (start) begin
          if (burst_len == '0) state_nx = S_DONE;
          else if (dir)        state_nx = S_FETCH;
          else                 state_nx = S_LOW;
        end
      end
      S_FETCH: if (s_valid) state_nx = S_LOW;
      S_LOW:   if (ph_cnt == LOW_LAST) state_nx = S_HIGH;
      S_HIGH: begin
        if (high_end && !stall) begin
          if (words_rem == '0) state_nx = dir_q ? S_DONE : S_DRAIN;
          else                 state_nx = dir_q ? S_FETCH : S_LOW;
        end
      end
      S_DRAIN: if (!m_valid || m_ready) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT;
      ph_cnt      <= '0;
      init_cnt    <= '0;
      initialized <= 1'b0;
      dir_q       <= 1'b0;
      held        <= 1'b0;
      words_left  <= '0;
    end else begin
      state <= state_nx;
      held  <= stall;

      if (state_nx != state)
        ph_cnt <= '0;
      else if ((state == S_LOW) || ((state == S_HIGH) && !high_end))
        ph_cnt <= ph_cnt + PH_W'(1);

      if ((state == S_INIT) && (init_cnt != INIT_LAST))
        init_cnt <= init_cnt + INIT_W'(1);
      if ((state == S_INIT) && (state_nx == S_IDLE))
        initialized <= 1'b1;

      if (start_ok) begin
        dir_q      <= dir;
        words_left <= burst_len;
      end else if (word_dec) begin
        words_left <= words_left - LEN_W'(1);
      end
    end
  end

  // Data path: DQ output latch, read holding register, optional checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      nand_dq_out <= '0;
      nand_dq_oe  <= 1'b0;
      m_data      <= '0;
      m_valid     <= 1'b0;
    end else begin
      if (fetch_hs) begin
        nand_dq_out <= s_data;
        nand_dq_oe  <= 1'b1;
      end else if (state_nx == S_DONE) begin
        nand_dq_oe  <= 1'b0;
      end

      if (capture) begin
        m_data  <= nand_dq_in;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef ONFI_IO_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)         checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (fetch_hs) checksum <= checksum ^ s_data;
    else if (capture)  checksum <= checksum ^ nand_dq_in;
  end
`endif

endmodule

// File: doc/onfi_burst_io.md
Name: onfi_burst_io

Overview:
Parametrised NAND data-path IO engine. Moves a multi-word burst between the controller's streaming interfaces and the ONFI DQ bus. Generates the read/write strobe with programmable low/high cycle counts, a programmable read-capture point and valid/ready backpressure on both sides. Sits between the command sequencer and the DQ pad ring; direction is selected per burst at runtime.

Parameters:
DATA_W, 16, DQ/stream width (8 or 16).
T_SETUP, 4, strobe-low cycles per word (>=1); maps to t_wp / t_rea.
T_HOLD, 2, strobe-high cycles per word (>=1); maps to t_wh / t_reh.
T_CAPTURE, 3, strobe-low cycle (1..T_SETUP) on which nand_dq_in is sampled for reads.
INIT_CYCLES, 15, post-reset settle count before the block is usable.
LEN_W, 12, width of the burst length and remaining-word counter.

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  burst request; sampled only when busy=0
dir  in  1  0=read from NAND, 1=write to NAND; latched on start
burst_len  in  LEN_W  words in burst; latched on start
s_data  in  DATA_W  write stream data
s_valid  in  1  write stream valid
s_ready  out  1  write stream ready
m_data  out  DATA_W  read stream data
m_valid  out  1  read stream valid
m_ready  in  1  read stream ready
nand_dq_in  in  DATA_W  DQ pad input
nand_dq_out  out  DATA_W  DQ pad output
nand_dq_oe  out  1  DQ output enable
strobe_n  out  1  WE#/RE# strobe, active low
busy  out  1  high when not IDLE
initialized  out  1  sticky high after init count
done  out  1  one-cycle pulse at burst end
words_left  out  LEN_W  remaining words in burst

Behaviour:
- One clock. Reset is synchronous, active-high. All state updates on posedge clk.
- Reset values: strobe_n=1, nand_dq_oe=0, nand_dq_out=0, m_valid=0, m_data=0, s_ready=0, busy=1, initialized=0, done=0, words_left=0. All counters are 0 and the state is INIT.
- States: INIT, IDLE, FETCH, LOW, HIGH, DRAIN, DONE.
- INIT: counts INIT_CYCLES cycles, then goes to IDLE and sets initialized=1. initialized stays 1 until reset.
- IDLE: busy=0. On start=1, latch dir and burst_len into words_left, then go to FETCH (dir=1) or LOW (dir=0) on the next cycle. burst_len=0 goes straight to DONE. start is ignored in every other state.
- Write path:
  - FETCH: s_ready=1 and strobe_n=1.
  - On s_valid&s_ready, latch s_data into nand_dq_out, set nand_dq_oe=1 and go to LOW.
  - With no s_valid, FETCH waits indefinitely.
- Read path: nand_dq_oe stays 0 for the whole read burst.
- LOW: strobe_n=0 for exactly T_SETUP cycles. For reads, nand_dq_in is captured on low cycle T_CAPTURE (1-based) into a holding register.
- HIGH: strobe_n=1 for exactly T_HOLD cycles. nand_dq_out stays stable through HIGH. words_left decrements on the last HIGH cycle. After the last HIGH cycle:
  - words_left>0 and write: go to FETCH.
  - words_left>0 and read: go to LOW, gated as below.
  - words_left=0: go to DRAIN (read) or DONE (write).
- Read output register:
  - One-deep. The held word is presented with m_valid=1 on the cycle after the capture cycle.
  - m_data is stable while m_valid=1 and m_ready=0.
  - A new LOW phase starts only if m_valid=0, or if m_valid=1 and m_ready=1 in that cycle. Otherwise the block stalls in HIGH with strobe_n=1.
- DRAIN: waits for the last word's m_valid&m_ready, then goes to DONE.
- DONE: done=1 for one cycle, nand_dq_oe=0, then IDLE.
- Unstalled word period is T_SETUP+T_HOLD cycles. A write burst of N words with s_valid held high takes N*(T_SETUP+T_HOLD+1) cycles from start to done, excluding the start cycle.
- Reset mid-burst: return to INIT, re-run the init count and clear initialized. Any pending read word is discarded, and done is not pulsed.

Optional Feature:
ONFI_IO_CHECKSUM_EN: when defined, adds output port checksum (DATA_W). It is cleared when start is accepted and XOR-accumulates every word transferred (written word at the FETCH handshake, read word at capture). Its value is final when done=1 and holds until the next accepted start; reset value is 0. When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then idle: initialized rises exactly INIT_CYCLES=15 cycles after reset deasserts; start pulsed during INIT is ignored and busy stays 1.
- Write burst, len=3, s_data 0x1111/0x2222/0x3333, s_valid held high: three strobe_n low pulses of 4 cycles each, high for 2 cycles, nand_dq_out matches per word, done at cycle 3*7 after start accept; checksum=0x0000.
- Read burst, len=4, nand_dq_in changes every cycle, m_ready=1: m_data equals the dq value on low cycle 3 of each pulse and words_left counts 4->0.
- Read with m_ready=0 for 10 cycles after the first word: strobe_n stays high with no second pulse, m_data stays stable, and the burst resumes the cycle m_ready rises.
- burst_len=0 and start: done pulses the next cycle with no strobe activity and nand_dq_oe=0.
- reset asserted during the second LOW of a write burst: strobe_n=1 and nand_dq_oe=0 the next cycle, no done pulse, and re-initialization completes after 15 cycles.
